// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: PID values, PID type field, CRC seeds, TX FSM states.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // PID[1:0] selects the packet shape
  localparam logic [1:0] PT_SPECIAL   = 2'b00;
  localparam logic [1:0] PT_TOKEN     = 2'b01;
  localparam logic [1:0] PT_HANDSHAKE = 2'b10;
  localparam logic [1:0] PT_DATA      = 2'b11;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_TOK1, ST_TOK2, ST_DATA, ST_CRC_LO, ST_CRC_HI
  } tx_state_e;

  function automatic logic [4:0] rev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

endpackage

// File: rtl/crc16_byte.sv
// Next CRC16 (poly 0x8005, reflected register form) after one byte, LSB first.
module crc16_byte (
  input  logic [15:0] c,
  input  logic [7:0]  d,
  output logic [15:0] c_out
);
  logic [15:0] r;

  always_comb begin
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 16'hA001 : 16'h0000);
    end
    c_out = r;
  end
endmodule

// File: rtl/crc5.sv
// USB token CRC5 (x^5+x^2+1) over an 11-bit field sent LSB first.
// c_out is the complemented remainder with bit 4 as the first bit on the wire.
module crc5 (
  input  logic [4:0]  c,
  input  logic [10:0] d,
  output logic [4:0]  c_out
);
  logic [4:0] r;

  always_comb begin
    r = c;
    for (int i = 0; i < 11; i++) begin
      r = {r[3:0], 1'b0} ^ (((d[i] ^ r[4]) == 1'b1) ? 5'h05 : 5'h00);
    end
    c_out = ~r;
  end
endmodule

// File: rtl/usb_pkt_tx.sv
// USB TX packet builder: handshake/token/SOF/DATA bytes with CRC5/CRC16 appended, one byte per handshake.
// Define USB_PKT_TX_SOF_EN to build SOF from tx_frame; otherwise SOF is an ordinary addr/endp token.
module usb_pkt_tx
  import usb_pkg::*;
#(
  parameter int MAX_PKT_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  tx_pid,
  input  logic [6:0]  tx_addr,
  input  logic [3:0]  tx_endp,
  input  logic [10:0] tx_frame,
  input  logic        tx_zlp,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_data_valid,
  input  logic        tx_data_last,
  output logic        tx_data_ready,
  output logic        tx_len_err,
  output logic        tx_to_sop,
  output logic        tx_to_eop,
  output logic        tx_to_valid,
  input  logic        tx_to_ready,
  output logic [7:0]  tx_to_data,
  output logic        tx_con_pid_en,
  output logic [3:0]  tx_con_pid
);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_LEN - 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       dat_q, dat_d;
  logic             vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, pen_q, pen_d;
  logic             rdy_q, rdy_d, lerr_q, lerr_d, zlp_q, zlp_d, done_q, done_d;
  logic [3:0]       pid_q, pid_d;
  logic [10:0]      tok_q, tok_d, tok_load;
  logic [15:0]      crc_q, crc_d, crc16_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       crc5_out;
  logic             advance;

`ifdef USB_PKT_TX_SOF_EN
  assign tok_load = (tx_pid == PID_SOF) ? tx_frame : {tx_endp, tx_addr};
`else
  logic unused_frame;
  assign unused_frame = ^tx_frame;
  assign tok_load     = {tx_endp, tx_addr};
`endif

  crc5 u_crc5 (.c(CRC5_INIT), .d(tok_q), .c_out(crc5_out));
  crc16_byte u_crc16 (.c(crc_q), .d(tx_data), .c_out(crc16_nxt));

  // The output register may be refilled when empty or when its byte leaves this cycle
  assign advance       = ~vld_q | tx_to_ready;
  assign tx_data_ready = (state_q == ST_DATA) & ~done_q & advance;

  always_comb begin
    state_d = state_q; dat_d = dat_q; vld_d = vld_q; sop_d = sop_q; eop_d = eop_q;
    pen_d = pen_q; rdy_d = rdy_q; lerr_d = 1'b0; zlp_d = zlp_q; done_d = done_q;
    pid_d = pid_q; tok_d = tok_q; crc_d = crc_q; cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (tx_valid) begin
        state_d = ST_PID; dat_d = {~tx_pid, tx_pid}; vld_d = 1'b1; sop_d = 1'b1; pen_d = 1'b1;
        eop_d = (tx_pid[1:0] == PT_HANDSHAKE) | (tx_pid[1:0] == PT_SPECIAL);
        rdy_d = 1'b0; pid_d = tx_pid; zlp_d = tx_zlp; tok_d = tok_load;
        crc_d = CRC16_INIT; cnt_d = '0; done_d = 1'b0;
      end
      ST_PID: if (tx_to_ready) begin
        sop_d = 1'b0; pen_d = 1'b0;
        case (pid_q[1:0])
          PT_TOKEN: begin state_d = ST_TOK1; dat_d = tok_q[7:0]; end
          PT_DATA: begin
            if (zlp_q) begin state_d = ST_CRC_LO; dat_d = ~crc_q[7:0]; end
            else begin state_d = ST_DATA; vld_d = 1'b0; end
          end
          default: begin state_d = ST_IDLE; vld_d = 1'b0; eop_d = 1'b0; rdy_d = 1'b1; end
        endcase
      end
      ST_TOK1: if (tx_to_ready) begin
        state_d = ST_TOK2; dat_d = {rev5(crc5_out), tok_q[10:8]}; eop_d = 1'b1;
      end
      ST_DATA: if (advance) begin
        if (done_q) begin
          state_d = ST_CRC_LO; dat_d = ~crc_q[7:0]; vld_d = 1'b1;
        end else if (tx_data_valid) begin
          dat_d = tx_data; vld_d = 1'b1; crc_d = crc16_nxt; cnt_d = cnt_q + CNT_W'(1);
          done_d = tx_data_last | (cnt_q == LAST_IDX);
          lerr_d = ~tx_data_last & (cnt_q == LAST_IDX);
        end else begin
          vld_d = 1'b0;
        end
      end
      ST_CRC_LO: if (tx_to_ready) begin
        state_d = ST_CRC_HI; dat_d = ~crc_q[15:8]; eop_d = 1'b1;
      end
      ST_TOK2, ST_CRC_HI: if (tx_to_ready) begin
        state_d = ST_IDLE; vld_d = 1'b0; eop_d = 1'b0; rdy_d = 1'b1;
      end
      default: begin state_d = ST_IDLE; vld_d = 1'b0; rdy_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; dat_q <= '0; vld_q <= 1'b0; sop_q <= 1'b0; eop_q <= 1'b0;
      pen_q <= 1'b0; rdy_q <= 1'b1; lerr_q <= 1'b0; zlp_q <= 1'b0; done_q <= 1'b0;
      pid_q <= '0; tok_q <= '0; crc_q <= '0; cnt_q <= '0;
    end else begin
      state_q <= state_d; dat_q <= dat_d; vld_q <= vld_d; sop_q <= sop_d; eop_q <= eop_d;
      pen_q <= pen_d; rdy_q <= rdy_d; lerr_q <= lerr_d; zlp_q <= zlp_d; done_q <= done_d;
      pid_q <= pid_d; tok_q <= tok_d; crc_q <= crc_d; cnt_q <= cnt_d;
    end
  end

  assign tx_ready      = rdy_q;
  assign tx_len_err    = lerr_q;
  assign tx_to_sop     = sop_q;
  assign tx_to_eop     = eop_q;
  assign tx_to_valid   = vld_q;
  assign tx_to_data    = dat_q;
  assign tx_con_pid_en = pen_q;
  assign tx_con_pid    = pid_q;
endmodule

// File: tb/tb_usb_pkt_tx.sv
// Randomized bench for usb_pkt_tx: a driver pushes expected bytes from a bit-serial CRC model,
// a monitor pops and compares each byte accepted on the control_t side.
module tb_usb_pkt_tx;
  import usb_pkg::*;

  localparam int MAXL = 64;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] dat;
    logic       sop, eop, pen, lerr;
    logic [3:0] pid;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] tx_pid = '0; logic [6:0] tx_addr = '0; logic [3:0] tx_endp = '0;
  logic [10:0] tx_frame = '0; logic tx_zlp = 1'b0, tx_valid = 1'b0, tx_ready;
  logic [7:0] tx_data = '0; logic tx_data_valid = 1'b0, tx_data_last = 1'b0, tx_data_ready;
  logic tx_len_err, tx_to_sop, tx_to_eop, tx_to_valid, tx_to_ready = 1'b1;
  logic [7:0] tx_to_data; logic tx_con_pid_en; logic [3:0] tx_con_pid;

  exp_t sb_q[$];
  int n_checks = 0, n_fail = 0, exp_lerr = 0, lerr_seen = 0;
  bit stall_en = 1'b0;

  usb_pkt_tx #(.MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
    .tx_frame(tx_frame), .tx_zlp(tx_zlp), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_last(tx_data_last),
    .tx_data_ready(tx_data_ready), .tx_len_err(tx_len_err), .tx_to_sop(tx_to_sop),
    .tx_to_eop(tx_to_eop), .tx_to_valid(tx_to_valid), .tx_to_ready(tx_to_ready),
    .tx_to_data(tx_to_data), .tx_con_pid_en(tx_con_pid_en), .tx_con_pid(tx_con_pid));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic s, input logic e, input logic p,
                          input logic l, input logic [3:0] pid);
    exp_t x;
    x.dat = d; x.sop = s; x.eop = e; x.pen = p; x.lerr = l; x.pid = pid;
    sb_q.push_back(x);
    if (l) exp_lerr++;
  endtask

  // CRC5 in reflected form: register bit 0 is the next bit on the wire
  function automatic logic [4:0] m_crc5(input logic [10:0] f);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) r = (r[0] ^ f[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return ~r;
  endfunction

  // CRC16 as textbook polynomial division over the serial bit stream, then reversed into wire order
  function automatic logic [15:0] m_crc16(input bq_t p);
    logic [15:0] r, f;
    r = 16'hFFFF;
    foreach (p[k]) for (int i = 0; i < 8; i++)
      r = {r[14:0], 1'b0} ^ ((p[k][i] ^ r[15]) ? 16'h8005 : 16'h0000);
    r = ~r;
    for (int i = 0; i < 16; i++) f[i] = r[15-i];
    return f;
  endfunction

  function automatic logic [10:0] tok_of(input logic [3:0] pid, input logic [6:0] a,
                                         input logic [3:0] e, input logic [10:0] fr);
`ifdef USB_PKT_TX_SOF_EN
    if (pid == PID_SOF) return fr;
`else
    if (fr == 11'h7FF && pid == PID_SOF) return {e, a};
`endif
    return {e, a};
  endfunction

  task automatic model_push(input logic [3:0] pid, input logic [10:0] tok, input bit zlp,
                            input bq_t pay, input bit has_last);
    bq_t sent; int n; logic [15:0] c; logic [4:0] c5;
    push_exp({~pid, pid}, 1, (pid[1:0] == PT_HANDSHAKE) || (pid[1:0] == PT_SPECIAL), 1, 0, pid);
    if (pid[1:0] == PT_TOKEN) begin
      c5 = m_crc5(tok);
      push_exp(tok[7:0], 0, 0, 0, 0, pid);
      push_exp({c5, tok[10:8]}, 0, 1, 0, 0, pid);
    end else if (pid[1:0] == PT_DATA) begin
      n = zlp ? 0 : ((pay.size() > MAXL) ? MAXL : pay.size());
      for (int i = 0; i < n; i++) begin
        push_exp(pay[i], 0, 0, 0, (i == MAXL-1) && !(has_last && pay.size() == MAXL), pid);
        sent.push_back(pay[i]);
      end
      c = m_crc16(sent);
      push_exp(c[7:0], 0, 0, 0, 0, pid);
      push_exp(c[15:8], 0, 1, 0, 0, pid);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {tx_ready, tx_data_ready, tx_len_err, tx_to_sop, tx_to_eop, tx_to_valid,
                 tx_to_data, tx_con_pid_en, tx_con_pid}, 32'h40000);
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT idle again
  task automatic drive_pkt(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e,
                           input logic [10:0] fr, input bit zlp, input bq_t pay,
                           input bit has_last, input bit stall, input bit poke,
                           input bit rst_mid, input bit chk_lat);
    int idx, guard; bit consumed, is_data, poked;
    is_data = (pid[1:0] == PT_DATA) && !zlp && pay.size() > 0;
    stall_en = stall; guard = 0; idx = 0; poked = 0;
    while (!tx_ready && guard < 500) begin @(posedge clk); #1; guard++; end
    if (guard >= 500) check("start_timeout", 0, 1);
    tx_pid = pid; tx_addr = a; tx_endp = e; tx_frame = fr; tx_zlp = zlp; tx_valid = 1'b1;
    if (is_data) begin
      tx_data = pay[0]; tx_data_last = has_last && pay.size() == 1; tx_data_valid = 1'b1;
    end
    if (chk_lat) begin
      @(posedge clk); #1; tx_valid = 1'b0;
      @(negedge clk); check("lat_busy", {tx_ready, tx_to_sop}, 2'b01);
      @(negedge clk); check("lat_ready", tx_ready, 1);
      @(posedge clk); #1;
      return;
    end
    guard = 0;
    forever begin
      @(negedge clk);
      if (guard == 0 && is_data) check("idle_no_consume", tx_data_ready, 0);
      if (idx >= MAXL) check("trunc_data_rdy", tx_data_ready, 0);
      consumed = tx_data_valid && tx_data_ready;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      if (consumed) idx++;
      guard++;
      if (!is_data || idx == pay.size() || tx_ready || guard > 2000) break;
      if (rst_mid && idx == 4) begin
        rst_n = 1'b0; #1; sb_q.delete();
        @(negedge clk); check_reset_vals("reset_mid_pkt");
        @(posedge clk); #1; rst_n = 1'b1; tx_data_valid = 1'b0; tx_data_last = 1'b0;
        return;
      end
      if (!tx_data_valid || consumed) begin
        tx_data = pay[idx]; tx_data_last = has_last && idx == pay.size() - 1;
        tx_data_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (poke && idx == 2 && !poked) begin tx_valid = 1'b1; tx_pid = PID_NAK; poked = 1; end
    end
    if (guard > 2000) check("payload_timeout", 0, 1);
    tx_data_valid = 1'b0; tx_data_last = 1'b0; guard = 0;
    while (!tx_ready && guard < 2000) begin @(posedge clk); #1; guard++; end
    if (guard >= 2000) check("done_timeout", 0, 1);
    check("sb_drain", sb_q.size(), 0);
  endtask

  task automatic rand_pkt();
    logic [3:0] pids[10];
    logic [3:0] pid; logic [6:0] a; logic [3:0] e; logic [10:0] fr; bit zlp, st; bq_t pay;
    pids = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_DATA0, PID_DATA1,
             PID_ACK, PID_NAK, PID_STALL, 4'b1100};
    pid = pids[$urandom_range(0, 9)];
    a = 7'($urandom); e = 4'($urandom); fr = 11'($urandom);
    zlp = ($urandom_range(0, 5) == 0); st = $urandom_range(0, 1) == 1;
    for (int i = 0; i < int'($urandom_range(1, 20)); i++) pay.push_back(8'($urandom));
    model_push(pid, tok_of(pid, a, e, fr), zlp, pay, 1);
    drive_pkt(pid, a, e, fr, zlp, pay, 1, st, 0, 0, 0);
  endtask

  // Transmit-side ready pattern
  initial forever begin
    @(posedge clk); #1;
    tx_to_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: pops one expected byte per accepted output byte
  initial begin : monitor
    logic [10:0] prev; bit stalled; exp_t x;
    stalled = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 0;
      else begin
        if (tx_len_err) begin
          lerr_seen++;
          check("len_err_pos", {tx_to_valid, (sb_q.size() != 0) ? sb_q[0].lerr : 1'b0}, 2'b11);
        end
        if (stalled) check("hold_while_stalled", {tx_to_valid, tx_to_sop, tx_to_eop, tx_to_data}, prev);
        stalled = tx_to_valid && !tx_to_ready;
        prev = {tx_to_valid, tx_to_sop, tx_to_eop, tx_to_data};
        if (tx_to_valid && tx_to_ready) begin
          if (sb_q.size() == 0) check("unexpected_byte", {24'h0, tx_to_data}, 32'hFFFF_FFFF);
          else begin
            x = sb_q.pop_front();
            check("pkt_byte {dat,sop,eop,pid_en,pid}",
                  {tx_to_data, tx_to_sop, tx_to_eop, tx_con_pid_en, tx_con_pid},
                  {x.dat, x.sop, x.eop, x.pen, x.pid});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bq_t pay, big, none;
    repeat (3) @(posedge clk);
    @(negedge clk); check_reset_vals("reset_state");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    push_exp(8'hD2, 1, 1, 1, 0, PID_ACK);
    drive_pkt(PID_ACK, 0, 0, 0, 0, none, 1, 0, 0, 0, 1);
    check("ack_drain", sb_q.size(), 0);

    push_exp(8'h2D, 1, 0, 1, 0, PID_SETUP); push_exp(8'h00, 0, 0, 0, 0, PID_SETUP);
    push_exp(8'h10, 0, 1, 0, 0, PID_SETUP);
    drive_pkt(PID_SETUP, 0, 0, 0, 0, none, 1, 0, 0, 0, 0);

    push_exp(8'hC3, 1, 0, 1, 0, PID_DATA0); push_exp(8'h00, 0, 0, 0, 0, PID_DATA0);
    push_exp(8'h00, 0, 1, 0, 0, PID_DATA0);
    drive_pkt(PID_DATA0, 0, 0, 0, 1, none, 1, 0, 0, 0, 0);

    pay = '{8'h00, 8'h01, 8'h02, 8'h03};
    model_push(PID_DATA1, 0, 0, pay, 1);
    drive_pkt(PID_DATA1, 0, 0, 0, 0, pay, 1, 0, 0, 0, 0);

    for (int i = 0; i < MAXL; i++) big.push_back(8'($urandom));
    model_push(PID_DATA0, 0, 0, big, 1);
    drive_pkt(PID_DATA0, 0, 0, 0, 0, big, 1, 0, 0, 0, 0);
    model_push(PID_DATA0, 0, 0, big, 1);
    drive_pkt(PID_DATA0, 0, 0, 0, 0, big, 1, 1, 1, 0, 0);

    big.push_back(8'hA5); big.push_back(8'h5A);
    model_push(PID_DATA1, 0, 0, big, 0);
    drive_pkt(PID_DATA1, 0, 0, 0, 0, big, 0, 1, 0, 0, 0);

    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    model_push(PID_DATA0, 0, 0, pay, 1);
    drive_pkt(PID_DATA0, 0, 0, 0, 0, pay, 1, 0, 0, 1, 0);
    model_push(PID_IN, {4'h5, 7'h2A}, 0, none, 1);
    drive_pkt(PID_IN, 7'h2A, 4'h5, 0, 0, none, 1, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) rand_pkt();

    stall_en = 1'b0;
    repeat (4) @(posedge clk);
    check("len_err_pulses", lerr_seen, exp_lerr);
    check("final_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
